// File: rtl/lane_fold_reducer_pkg.sv
// Shared constants and helpers for the lane fold reducer: tree depth derivation,
// signature mode encoding and a width-generic rotate-left.
package lane_fold_reducer_pkg;

  // Widest lane the rotate helper supports; callers zero-extend into this width.
  localparam int unsigned ROT_MAX_W = 1024;
  localparam int unsigned ROT_IDX_W = 10;

  localparam logic MODE_FOLD = 1'b0;
  localparam logic MODE_SIG  = 1'b1;

  // Ceiling log2; c_log_2(1) = 0.
  function automatic int unsigned c_log_2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

  // Number of registered tree levels; a single lane still gets one register stage.
  function automatic int unsigned fold_levels(input int unsigned n);
    int unsigned c;
    c = c_log_2(n);
    return (c < 1) ? 1 : c;
  endfunction

  // Rotate the low 'width' bits of v left by (amt mod width); upper bits return as 0.
  function automatic logic [ROT_MAX_W-1:0] rotl(input logic [ROT_MAX_W-1:0] v,
                                                input int unsigned amt,
                                                input int unsigned width);
    logic [ROT_MAX_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < ROT_MAX_W; i++) begin
      if (i < width) r[ROT_IDX_W'((i + amt) % width)] = v[ROT_IDX_W'(i)];
    end
    return r;
  endfunction

endpackage

// File: rtl/lane_fold_reducer_xor_tree_stage.sv
// One registered level of the XOR fold tree: folds adjacent lane pairs and carries
// the beat's valid and mode bits alongside. Frozen entirely when en is low.
module xor_tree_stage #(
  parameter int unsigned PAIRS      = 1,
  parameter int unsigned LANE_WIDTH = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          in_valid,
  input  logic                          in_mode,
  input  logic [2*PAIRS*LANE_WIDTH-1:0] in_data,
  output logic                          out_valid,
  output logic                          out_mode,
  output logic [PAIRS*LANE_WIDTH-1:0]   out_data
);

  logic [PAIRS*LANE_WIDTH-1:0] fold;

  // XOR each adjacent pair of lanes into one lane.
  always_comb begin
    fold = '0;
    for (int unsigned p = 0; p < PAIRS; p++) begin
      fold[p*LANE_WIDTH +: LANE_WIDTH] = in_data[2*p*LANE_WIDTH +: LANE_WIDTH] ^
                                         in_data[(2*p+1)*LANE_WIDTH +: LANE_WIDTH];
    end
  end

  // Stage register; data only loads on a valid beat so it holds across bubbles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_mode  <= 1'b0;
      out_data  <= '0;
    end else if (en) begin
      out_valid <= in_valid;
      out_mode  <= in_mode;
      if (in_valid) out_data <= fold;
    end
  end

endmodule

// File: rtl/lane_fold_reducer.sv
// Folds a packed multi-lane word to one lane through a pipelined XOR tree with
// valid/ready backpressure, keeps a signature over mode-1 beats, counts output beats
// and registers a (optionally rotated) broadcast of one lane to all lanes.
module lane_fold_reducer
  import lane_fold_reducer_pkg::*;
#(
  parameter int unsigned LANE_WIDTH      = 64,
  parameter int unsigned NUM_LANES       = 4,
  parameter int unsigned PERF_CNTR_WIDTH = 10
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic                            mode,
  input  logic                            sig_clear,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [NUM_LANES*LANE_WIDTH-1:0] in_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [LANE_WIDTH-1:0]           out_data,
  output logic [LANE_WIDTH-1:0]           sig_out,
  input  logic [LANE_WIDTH-1:0]           bcast_in,
  input  logic                            bcast_rot,
  output logic [NUM_LANES*LANE_WIDTH-1:0] bcast_out,
  output logic [PERF_CNTR_WIDTH-1:0]      beat_count
);

  localparam int unsigned LEVELS   = fold_levels(NUM_LANES);
  localparam int unsigned PadLanes = 1 << LEVELS;

  // Lane offset of the input of tree level k inside the flattened node vector.
  function automatic int unsigned lvl_off(input int unsigned k);
    return 2 * PadLanes - 2 * (PadLanes >> k);
  endfunction

  logic                                 ready_q;
  logic                                 stall, advance, accept, handshake, out_mode;
  logic [(2*PadLanes-1)*LANE_WIDTH-1:0] tree;
  logic [LEVELS:0]                      lvl_valid, lvl_mode;
  logic [LANE_WIDTH-1:0]                sig_q, sig_d;
  logic [ROT_MAX_W-1:0]                 sig_ext, sig_rot, bc_ext, bc_rot;
  logic [PERF_CNTR_WIDTH-1:0]           cnt_q, cnt_d;
  logic [NUM_LANES*LANE_WIDTH-1:0]      bcast_q, bcast_d;

  // A stalled output freezes the whole pipe, so bubbles are kept in place.
  assign stall     = out_valid & ~out_ready;
  assign advance   = ~stall;
  assign in_ready  = ready_q & ~stall;
  assign accept    = in_valid & in_ready;
  assign handshake = out_valid & out_ready;

  assign lvl_valid[0] = accept;
  assign lvl_mode[0]  = mode;

  // Lanes beyond NUM_LANES up to the next power of two fold in as zero.
  if (PadLanes > NUM_LANES) begin : g_pad
    assign tree[PadLanes*LANE_WIDTH-1:0] = {{((PadLanes-NUM_LANES)*LANE_WIDTH){1'b0}}, in_data};
  end else begin : g_nopad
    assign tree[PadLanes*LANE_WIDTH-1:0] = in_data;
  end

  for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
    localparam int unsigned Pairs  = PadLanes >> (k + 1);
    localparam int unsigned InOff  = lvl_off(k);
    localparam int unsigned OutOff = lvl_off(k + 1);
    xor_tree_stage #(
      .PAIRS      (Pairs),
      .LANE_WIDTH (LANE_WIDTH)
    ) u_stage (
      .clk       (ACLK),
      .rst       (ARESET),
      .en        (advance),
      .in_valid  (lvl_valid[k]),
      .in_mode   (lvl_mode[k]),
      .in_data   (tree[InOff*LANE_WIDTH +: 2*Pairs*LANE_WIDTH]),
      .out_valid (lvl_valid[k+1]),
      .out_mode  (lvl_mode[k+1]),
      .out_data  (tree[OutOff*LANE_WIDTH +: Pairs*LANE_WIDTH])
    );
  end

  assign out_valid  = lvl_valid[LEVELS];
  assign out_mode   = lvl_mode[LEVELS];
  assign out_data   = tree[lvl_off(LEVELS)*LANE_WIDTH +: LANE_WIDTH];
  assign sig_out    = sig_q;
  assign beat_count = cnt_q;
  assign bcast_out  = bcast_q;

  // Signature and saturating beat counter; clear wins over an update on the same beat.
  always_comb begin
    sig_ext                   = '0;
    sig_ext[LANE_WIDTH-1:0]   = sig_q;
    sig_rot                   = rotl(sig_ext, 1, LANE_WIDTH);
    sig_d                     = sig_q;
    if (sig_clear) begin
      sig_d = '0;
    end else if (handshake && (out_mode == MODE_SIG)) begin
      sig_d = sig_rot[LANE_WIDTH-1:0] ^ out_data;
    end
    cnt_d = cnt_q;
    if (handshake && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  // Broadcast lane i is either a copy or the input rotated left by i.
  always_comb begin
    bc_ext                  = '0;
    bc_ext[LANE_WIDTH-1:0]  = bcast_in;
    bc_rot                  = '0;
    bcast_d                 = '0;
    for (int unsigned l = 0; l < NUM_LANES; l++) begin
      bc_rot = rotl(bc_ext, l % LANE_WIDTH, LANE_WIDTH);
      bcast_d[l*LANE_WIDTH +: LANE_WIDTH] = bcast_rot ? bc_rot[LANE_WIDTH-1:0] : bcast_in;
    end
  end

  // Top-level state; ready_q keeps in_ready low until the first edge out of reset.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      ready_q <= 1'b0;
      sig_q   <= '0;
      cnt_q   <= '0;
      bcast_q <= '0;
    end else begin
      ready_q <= 1'b1;
      sig_q   <= sig_d;
      cnt_q   <= cnt_d;
      bcast_q <= bcast_d;
    end
  end

endmodule

// File: tb/tb_lane_fold_reducer.sv
// Bench for lane_fold_reducer: directed steps plus a randomized run, checked against a
// queue-based model of accepted beats, the signature rule and the broadcast rule.
module tb_lane_fold_reducer;

  localparam int LW = 64;
  localparam int NL = 4;
  localparam int LAT = 2;

  logic            ACLK, ARESET;
  logic            mode, sig_clear, in_valid, in_ready, out_valid, out_ready, bcast_rot;
  logic [NL*LW-1:0] in_data, bcast_out;
  logic [LW-1:0]   out_data, sig_out, bcast_in;
  logic [9:0]      beat_count;

  // Second instance with a non-power-of-two lane count.
  logic            b_in_valid, b_in_ready, b_out_valid, b_zero;
  logic [3*LW-1:0] b_in_data, b_bcast_out;
  logic [LW-1:0]   b_out_data, b_sig_out, b_bcast_in;
  logic [9:0]      b_beat_count;

  lane_fold_reducer #(.LANE_WIDTH(LW), .NUM_LANES(NL), .PERF_CNTR_WIDTH(10)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .mode(mode), .sig_clear(sig_clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .sig_out(sig_out),
    .bcast_in(bcast_in), .bcast_rot(bcast_rot), .bcast_out(bcast_out),
    .beat_count(beat_count)
  );

  lane_fold_reducer #(.LANE_WIDTH(LW), .NUM_LANES(3), .PERF_CNTR_WIDTH(10)) dut3 (
    .ACLK(ACLK), .ARESET(ARESET), .mode(b_zero), .sig_clear(b_zero),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(1'b1), .out_data(b_out_data), .sig_out(b_sig_out),
    .bcast_in(b_bcast_in), .bcast_rot(b_zero), .bcast_out(b_bcast_out),
    .beat_count(b_beat_count)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  typedef struct {
    logic [LW-1:0] d;
    logic          m;
    int            acc;
  } beat_t;

  beat_t          q[$];
  int             n_vec = 0, n_err = 0, cyc_n = 0, nv_seen = 0;
  logic [LW-1:0]  m_sig;
  int             m_cnt;
  logic [NL*LW-1:0] m_bc;
  bit             lat_chk = 0;

  // Values applied at the next falling edge by cyc().
  logic            drv_valid, drv_ready, drv_mode, drv_clr, drv_brot;
  logic [NL*LW-1:0] drv_data;
  logic [LW-1:0]   drv_bin;
  logic            last_in_ready;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [LW-1:0] rotl_m(input logic [LW-1:0] x, input int n);
    int s;
    s = n % LW;
    return (s == 0) ? x : ((x << s) | (x >> (LW - s)));
  endfunction

  function automatic logic [LW-1:0] fold_m(input logic [NL*LW-1:0] d);
    logic [LW-1:0] x;
    x = '0;
    for (int i = 0; i < NL; i++) x ^= d[i*LW +: LW];
    return x;
  endfunction

  function automatic logic [NL*LW-1:0] bcast_m(input logic [LW-1:0] b, input logic rot);
    logic [NL*LW-1:0] r;
    for (int i = 0; i < NL; i++) r[i*LW +: LW] = rot ? rotl_m(b, i) : b;
    return r;
  endfunction

  function automatic logic [NL*LW-1:0] lanes4(input logic [LW-1:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  // One clock cycle: apply inputs, check registered state, then advance the model.
  task automatic cyc();
    beat_t b;
    logic  acc, ohs;
    @(negedge ACLK);
    in_valid  = drv_valid;
    out_ready = drv_ready;
    mode      = drv_mode;
    sig_clear = drv_clr;
    in_data   = drv_data;
    bcast_in  = drv_bin;
    bcast_rot = drv_brot;
    #1;
    chk("sig_out", sig_out, m_sig);
    chk("beat_count", beat_count, m_cnt);
    chk("bcast_out", bcast_out, m_bc);
    chk("in_ready", in_ready, !(out_valid && !drv_ready));
    last_in_ready = in_ready;
    if (out_valid) nv_seen++;
    acc = drv_valid && in_ready;
    ohs = out_valid && drv_ready;
    if (ohs) begin
      if (q.size() == 0) begin
        chk("spurious_beat", out_valid, 1'b0);
      end else begin
        b = q.pop_front();
        chk("out_data", out_data, b.d);
        if (lat_chk) chk("latency", cyc_n - b.acc, LAT);
        if (b.m) m_sig = rotl_m(m_sig, 1) ^ b.d;
        if (m_cnt < 1023) m_cnt++;
      end
    end
    if (drv_clr) m_sig = '0;
    if (acc) begin
      b.d = fold_m(drv_data);
      b.m = drv_mode;
      b.acc = cyc_n;
      q.push_back(b);
    end
    m_bc = bcast_m(drv_bin, drv_brot);
    cyc_n++;
  endtask

  task automatic do_reset();
    @(negedge ACLK);
    drv_valid = 1'b0;
    in_valid  = 1'b0;
    #2 ARESET = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, '0);
    chk("rst_sig_out", sig_out, '0);
    chk("rst_beat_count", beat_count, '0);
    chk("rst_bcast_out", bcast_out, '0);
    @(negedge ACLK);
    ARESET = 1'b0;
    #1;
    chk("rst_in_ready_low", in_ready, 1'b0);
    q.delete();
    m_sig = '0;
    m_cnt = 0;
    m_bc  = bcast_m(drv_bin, drv_brot);
  endtask

  initial begin
    ARESET = 1'b1;
    {mode, sig_clear, in_valid, out_ready, bcast_rot} = '0;
    in_data = '0; bcast_in = '0;
    b_in_valid = 1'b0; b_in_data = '0; b_bcast_in = '0; b_zero = 1'b0;
    {drv_valid, drv_mode, drv_clr, drv_brot} = '0;
    drv_ready = 1'b1; drv_data = '0; drv_bin = '0;
    m_sig = '0; m_cnt = 0; m_bc = '0;
    repeat (2) @(negedge ACLK);
    do_reset();

    // Single beat: fold, exact latency, one-cycle valid, held data, no signature change.
    lat_chk = 1; nv_seen = 0;
    drv_data = lanes4(64'h1, 64'h2, 64'h4, 64'h8); drv_valid = 1;
    cyc();
    drv_valid = 0;
    repeat (5) cyc();
    chk("t1_valid_cycles", nv_seen, 1);
    chk("t1_hold_data", out_data, 64'hF);
    chk("t1_sig", sig_out, 64'h0);
    lat_chk = 0;

    // Back-to-back beats with a two-cycle stall on the first result.
    do_reset();
    drv_valid = 1; drv_data = lanes4(64'hA, 0, 0, 0); cyc();
    drv_data = lanes4(64'h3, 64'h8, 0, 0); cyc();
    drv_data = lanes4(64'hF, 64'h3, 0, 0); drv_ready = 0; cyc();
    chk("t2_in_ready_stall", last_in_ready, 1'b0);
    chk("t2_out_stall", out_data, 64'hA);
    cyc();
    chk("t2_in_ready_stall2", last_in_ready, 1'b0);
    drv_ready = 1; cyc();
    drv_valid = 0;
    repeat (5) cyc();
    chk("t2_count", beat_count, 10'd3);
    chk("t2_drained", q.size(), 0);

    // Signature: clear, two absorbed beats, then a clear on the handshake cycle.
    drv_clr = 1; cyc(); drv_clr = 0;
    drv_mode = 1; drv_data = lanes4(64'h1, 0, 0, 0);
    drv_valid = 1; cyc(); drv_valid = 0; repeat (3) cyc();
    chk("sig_first", sig_out, 64'h1);
    drv_valid = 1; cyc(); drv_valid = 0; repeat (3) cyc();
    chk("sig_second", sig_out, 64'h3);
    drv_valid = 1; cyc(); drv_valid = 0; cyc();
    drv_clr = 1; cyc(); drv_clr = 0; cyc();
    chk("sig_clear_wins", sig_out, 64'h0);
    chk("sig_count", beat_count, 10'd6);

    // Broadcast rotate and replicate.
    drv_bin = 64'h1; drv_brot = 1; cyc(); cyc();
    chk("bcast_rot", bcast_out, lanes4(64'h1, 64'h2, 64'h4, 64'h8));
    drv_brot = 0; cyc(); cyc();
    chk("bcast_rep", bcast_out, lanes4(64'h1, 64'h1, 64'h1, 64'h1));

    // Reset with two beats in flight after a non-zero signature.
    drv_data = lanes4(64'h5, 0, 0, 0); drv_valid = 1; cyc(); drv_valid = 0; repeat (3) cyc();
    chk("pre_rst_sig", sig_out, 64'h5);
    drv_valid = 1; drv_data = lanes4(64'h11, 0, 0, 0); cyc();
    drv_data = lanes4(64'h22, 0, 0, 0); cyc();
    do_reset();
    nv_seen = 0;
    repeat (6) cyc();
    chk("no_stale_beat", nv_seen, 0);

    // Three-lane instance: padding lane must fold as zero.
    @(negedge ACLK);
    b_in_data = {64'h6, 64'h5, 64'h3}; b_in_valid = 1;
    @(negedge ACLK);
    chk("nl3_not_yet", b_out_valid, 1'b0);
    b_in_data = {64'h4, 64'h2, 64'h1};
    @(negedge ACLK);
    b_in_valid = 0;
    chk("nl3_valid0", b_out_valid, 1'b1);
    chk("nl3_data0", b_out_data, 64'h0);
    @(negedge ACLK);
    chk("nl3_valid1", b_out_valid, 1'b1);
    chk("nl3_data1", b_out_data, 64'h7);
    @(negedge ACLK);
    chk("nl3_idle", b_out_valid, 1'b0);

    // Counter saturation.
    do_reset();
    drv_mode = 0; drv_valid = 1; drv_ready = 1;
    for (int i = 0; i < 1110; i++) begin
      drv_data = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      cyc();
    end
    chk("sat_count", beat_count, 10'd1023);

    // Randomized traffic with backpressure, mixed modes and occasional clears.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      drv_valid = ($urandom_range(3) != 0);
      drv_ready = ($urandom_range(2) != 0);
      drv_mode  = $urandom_range(1);
      drv_clr   = ($urandom_range(15) == 0);
      drv_data  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      drv_bin   = {$urandom, $urandom};
      drv_brot  = $urandom_range(1);
      cyc();
    end
    drv_valid = 0; drv_ready = 1; drv_clr = 0;
    repeat (6) cyc();
    chk("rand_drained", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lane_fold_reducer.md
Name: lane_fold_reducer

Overview:
- Parametrised successor to the multi-lane AXI folding logic used in synthesis-test wrappers. Each packed multi-lane word is reduced to one lane with a pipelined XOR tree, and one lane is broadcast back to all lanes.
- Adds valid/ready backpressure, a per-beat signature (MISR) mode, a rotating broadcast mode, and a beat counter.
- Sits between mem_interface-width buses (NUM_AXI × AXIM_DATA_WIDTH) and narrow top-level pins, so synthesis does not prune the wide datapath.

Parameters:
- LANE_WIDTH, 64: width of one lane (bits).
- NUM_LANES, 4: lane count, ≥1. Need not be a power of two.
- PERF_CNTR_WIDTH, 10: width of the beat counter.
- LEVELS, derived = max(1, C_LOG_2(NUM_LANES)): number of tree levels, each registered. Not overridable.

Ports:
- ACLK  in  1  clock.
- ARESET  in  1  asynchronous, active-high reset.
- mode  in  1  0 = plain fold, 1 = fold plus signature update. Sampled with in_data.
- sig_clear  in  1  synchronous clear of the signature register.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid & in_ready.
- in_data  in  NUM_LANES*LANE_WIDTH  packed lanes; lane i = bits [i*LANE_WIDTH +: LANE_WIDTH].
- out_valid  out  1  folded result valid.
- out_ready  in  1  downstream accepts the folded result.
- out_data  out  LANE_WIDTH  XOR of all lanes of one beat.
- sig_out  out  LANE_WIDTH  signature register.
- bcast_in  in  LANE_WIDTH  lane to broadcast.
- bcast_rot  in  1  0 = replicate, 1 = lane i rotated left by (i mod LANE_WIDTH).
- bcast_out  out  NUM_LANES*LANE_WIDTH  registered broadcast.
- beat_count  out  PERF_CNTR_WIDTH  saturating count of accepted output beats.

Behaviour:
- Clock and reset: single clock ACLK; ARESET is asynchronous and active-high. While ARESET is high, all state clears immediately: stage valids, stage data, sig_out, bcast_out, beat_count all 0; out_valid = 0; out_data = 0. in_ready is 1 from the first edge after ARESET deasserts.
- Reset mid-operation: every in-flight beat is discarded and nothing is replayed.
- Padding: lanes NUM_LANES .. 2^LEVELS-1 are tied to 0.
- Tree: level k XORs adjacent pairs from level k-1 into a register. Each stage carries {valid, mode}.
- Latency: an accepted beat appears on out_data/out_valid exactly LEVELS cycles later when no stall occurs. For NUM_LANES=1, LEVELS=1 and the block is a 1-cycle register.
- Throughput: 1 beat per cycle.
- Stall: stall = out_valid & ~out_ready. in_ready = ~stall. Stall freezes every stage (global enable), so bubbles are not collapsed. Beat order is preserved; no beat is lost or duplicated.
- out_data holds its value while out_valid is low.
- Signature update: on an output handshake (out_valid & out_ready) whose carried mode is 1, sig_out <= rotl1(sig_out) ^ out_data.
- Signature clear: sig_clear forces sig_out <= 0 and overrides a simultaneous update, so that beat is not absorbed.
- Mode-0 beats never alter sig_out.
- Beat counter: beat_count increments on every output handshake and saturates at 2^PERF_CNTR_WIDTH-1.
- Broadcast path: independent of the handshake and updated every cycle. bcast_out lane i <= bcast_rot ? rotl(bcast_in, i) : bcast_in. Latency 1.
- Widths: all arithmetic is bitwise, so there is no growth. Rotation amounts are taken mod LANE_WIDTH.

Decomposition:
- Shared package/header: C_LOG_2 (existing log.vh), the rotl function, the LEVELS derivation, and the MODE_FOLD/MODE_SIG constants.
- Sub-module xor_tree_stage: one registered level, parametrised by input pair count and LANE_WIDTH, with inputs en, in_valid and in_mode. It is instantiated LEVELS times in a generate loop.
- The top level holds the stall logic, signature, counter and broadcast.

Test Plan (NUM_LANES=4, LANE_WIDTH=64 unless noted):
- Lanes {0x1,0x2,0x4,0x8}, mode=0, out_ready=1 -> out_data=0xF with out_valid high for exactly 1 cycle, 2 cycles after acceptance; sig_out stays 0.
- Three back-to-back beats folding to 0xA, 0xB, 0xC, with out_ready low for 2 cycles while 0xA is presented -> in_ready low during the stall; outputs 0xA, 0xB, 0xC in order, none dropped or repeated; beat_count=3.
- sig_clear, then two mode=1 beats each folding to 0x1 -> sig_out=0x1, then 0x3. A third beat with sig_clear asserted on its handshake cycle -> sig_out=0.
- bcast_in=0x1, bcast_rot=1 -> bcast_out lanes {0x1,0x2,0x4,0x8} next cycle. With bcast_rot=0 -> four lanes of 0x1.
- ARESET pulsed while 2 beats are in flight -> out_valid, out_data, sig_out and beat_count are 0 immediately; no stale beat emerges afterwards.
- NUM_LANES=3, lanes {0x3,0x5,0x6} -> out_data=0x0 after 2 cycles. Then 1100 handshakes -> beat_count holds at 1023.
